// File: rtl/tcp_client_conn.sv
// tcp_client_conn: active-open TCP connection FSM; handles headers only, payload bypasses it.
module tcp_client_conn #(
   parameter int SYN_TIMEOUT = 1000,
   parameter int MAX_RETRIES = 3,
   parameter int TW_CYCLES   = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        open_req,
   input  logic        close_req,
   input  logic [31:0] isn,
   input  logic        seg_in_vld,
   output logic        seg_in_rdy,
   input  logic [3:0]  seg_in_flags,
   input  logic [31:0] seg_in_seq,
   input  logic [31:0] seg_in_ack,
   input  logic [15:0] seg_in_len,
   output logic        seg_out_vld,
   input  logic        seg_out_rdy,
   output logic [3:0]  seg_out_flags,
   output logic [31:0] seg_out_seq,
   output logic [31:0] seg_out_ack,
   output logic [2:0]  state_o,
   output logic        established,
   output logic        err_timeout
);
   typedef enum logic [2:0] {CLOSED, SYN_SENT, ESTABLISHED, FIN_WAIT_1, FIN_WAIT_2, LAST_ACK, TIME_WAIT} state_t;
   localparam logic [3:0] F_SYN = 4'b1000, F_ACK = 4'b0100, F_FIN = 4'b0010, F_RST = 4'b0001;
   state_t state, n_state;
   logic [31:0] snd_nxt, rcv_nxt, n_snd, n_rcv, e_seq, e_ack, rcv_data;
   logic [15:0] timer, n_tmr;
   logic [7:0]  retries, n_ret;
   logic [3:0]  e_flags;
   logic        emit, n_err, acc, rst_seg, seg, fin, seq_ok, ack_ok, can_emit;
   assign seg_in_rdy  = ~seg_out_vld;
   assign acc         = seg_in_vld & seg_in_rdy;
   assign rst_seg     = acc & seg_in_flags[0];
   assign seg         = acc & ~seg_in_flags[0];
   assign fin         = seg_in_flags[1];
   assign seq_ok      = seg_in_seq == rcv_nxt;
   assign ack_ok      = seg_in_flags[2] & (seg_in_ack == snd_nxt);
   assign can_emit    = ~seg_out_vld | seg_out_rdy;
   assign rcv_data    = rcv_nxt + {16'd0, seg_in_len} + {31'd0, fin};
   assign state_o     = state;
   assign established = state == ESTABLISHED;
   always_comb begin
      n_state = state;
      n_snd   = snd_nxt;
      n_rcv   = rcv_nxt;
      n_tmr   = timer;
      n_ret   = retries;
      n_err   = 1'b0;
      emit    = 1'b0;
      e_flags = F_ACK;
      e_seq   = snd_nxt;
      e_ack   = rcv_nxt;
      // past SYN_SENT an RST consumes the cycle; only an in-window one closes
      if (state > SYN_SENT && rst_seg) begin
         if (seq_ok) n_state = CLOSED;
      end else begin
         case (state)
            CLOSED: if (open_req & can_emit) begin
               n_state = SYN_SENT;
               n_snd   = isn;
               emit    = 1'b1;
               e_flags = F_SYN;
               e_seq   = isn;
               e_ack   = 32'd0;
               n_tmr   = 16'd0;
               n_ret   = 8'd0;
            end
            SYN_SENT: begin
               if (seg && seg_in_flags == (F_SYN | F_ACK) && seg_in_ack == snd_nxt + 32'd1) begin
                  n_state = ESTABLISHED;
                  n_snd   = snd_nxt + 32'd1;
                  n_rcv   = seg_in_seq + 32'd1;
                  emit    = 1'b1;
                  e_seq   = snd_nxt + 32'd1;
                  e_ack   = seg_in_seq + 32'd1;
               end else if (rst_seg && seg_in_flags == (F_RST | F_ACK) && seg_in_ack == snd_nxt + 32'd1)
                  n_state = CLOSED;
               else if (~seg_out_vld && timer == 16'(SYN_TIMEOUT - 1)) begin
                  n_tmr = 16'd0;
                  if (retries < 8'(MAX_RETRIES)) begin
                     emit    = 1'b1;
                     e_flags = F_SYN;
                     e_ack   = 32'd0;
                     n_ret   = retries + 8'd1;
                  end else begin
                     n_state = CLOSED;
                     n_err   = 1'b1;
                  end
               end else if (close_req)
                  n_state = CLOSED;
               else if (~seg_out_vld)
                  n_tmr = timer + 16'd1;
            end
            ESTABLISHED: begin
               if (seg && seq_ok) begin
                  n_rcv = rcv_data;
                  e_ack = rcv_data;
                  emit  = fin | (seg_in_len != 16'd0);
                  if (fin) begin
                     e_flags = F_ACK | F_FIN;
                     n_snd   = snd_nxt + 32'd1;
                     n_state = LAST_ACK;
                  end
               end else if (seg)
                  emit = 1'b1;
               else if (close_req && can_emit) begin
                  emit    = 1'b1;
                  e_flags = F_FIN | F_ACK;
                  n_snd   = snd_nxt + 32'd1;
                  n_state = FIN_WAIT_1;
               end
            end
            FIN_WAIT_1, FIN_WAIT_2: begin
               if (seg && fin && seq_ok) begin
                  n_rcv   = rcv_nxt + 32'd1;
                  emit    = 1'b1;
                  e_ack   = rcv_nxt + 32'd1;
                  n_tmr   = 16'd0;
                  n_state = TIME_WAIT;
               end else if (state == FIN_WAIT_1 && seg && ack_ok && !fin)
                  n_state = FIN_WAIT_2;
            end
            LAST_ACK: if (seg && ack_ok) n_state = CLOSED;
            TIME_WAIT: begin
               if (seg && fin) begin
                  emit  = 1'b1;
                  n_tmr = 16'd0;
               end else if (timer == 16'(TW_CYCLES - 1)) begin
                  n_state = CLOSED;
                  n_tmr   = 16'd0;
               end else
                  n_tmr = timer + 16'd1;
            end
            default: n_state = CLOSED;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= CLOSED;
         snd_nxt       <= 32'd0;
         rcv_nxt       <= 32'd0;
         timer         <= 16'd0;
         retries       <= 8'd0;
         err_timeout   <= 1'b0;
         seg_out_vld   <= 1'b0;
         seg_out_flags <= 4'd0;
         seg_out_seq   <= 32'd0;
         seg_out_ack   <= 32'd0;
      end else begin
         state       <= n_state;
         snd_nxt     <= n_snd;
         rcv_nxt     <= n_rcv;
         timer       <= n_tmr;
         retries     <= n_ret;
         err_timeout <= n_err;
         if (emit) begin
            seg_out_vld   <= 1'b1;
            seg_out_flags <= e_flags;
            seg_out_seq   <= e_seq;
            seg_out_ack   <= e_ack;
         end else if (seg_out_rdy) begin
            seg_out_vld   <= 1'b0;
            seg_out_flags <= 4'd0;
            seg_out_seq   <= 32'd0;
            seg_out_ack   <= 32'd0;
         end
      end
   end
endmodule
